// File: rtl/shift_sequencer_if.sv
// Handshake and operand bundle between execute-stage control and the shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start;
  logic [1:0]             op;
  logic [WIDTH-1:0]       data_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       data_out;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROTL unit: one single-bit shift step per cycle,
// with a start/busy/done handshake and a held result register.
module shift_sequencer #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  logic [1:0]             state;
  logic [WIDTH-1:0]       acc;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [1:0]             op_q;
  logic [WIDTH-1:0]       result;
  logic [WIDTH-1:0]       shifted;

  // One-position step of the accumulator for the captured operation.
  always_comb begin
    shifted = acc;
    case (op_q)
      OP_SLL:  shifted = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_ROTL: shifted = {acc[WIDTH-2:0], acc[WIDTH-1]};
      default: shifted = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            acc  <= bus.data_in;
            cnt  <= bus.shamt;
            op_q <= bus.op;
            // A zero amount skips SHIFT, so the operand is the result.
            if (bus.shamt == '0) begin
              result <= bus.data_in;
              state  <= DONE;
            end else begin
              state  <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc <= shifted;
          cnt <= cnt - SHAMT_WIDTH'(1);
          if (cnt == SHAMT_WIDTH'(1)) begin
            result <= shifted;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.data_out = result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: latency, results,
// handshake corner cases and reset behaviour.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_count;
  int   cycles;
  int   busy_cycles;
  int   done_before;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(bus.busy && bus.done)) else begin
        errors++;
        $error("[TB] FAIL busy_done_exclusive observed busy=%0b done=%0b expected not both", bus.busy, bus.done);
      end
      if (bus.done) done_count++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge of cycle 1 after the accepting edge.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = data;
    bus.shamt   = sh;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input int first_cycle, input int limit, output int n, output int nbusy);
    n     = first_cycle;
    nbusy = 0;
    while (!bus.done && n < limit) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    done_count  = 0;
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.op      = 2'($urandom_range(3));
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom_range(31));

    // Reset held two cycles with start asserted.
    @(negedge clk);
    bus.data_in = $urandom;
    @(negedge clk);
    check_output("reset_busy", 32'(bus.busy), 32'h0);
    check_output("reset_done", 32'(bus.done), 32'h0);
    check_output("reset_data_out", bus.data_out, 32'h0);
    reset     = 1'b0;
    bus.start = 1'b0;

    // SLL 1 by 31.
    apply_stimulus(2'b00, 32'h0000_0001, 5'd31);
    check_output("sll31_data_during_shift", bus.data_out, 32'h0);
    check_output("sll31_busy_cycle1", 32'(bus.busy), 32'h1);
    wait_done(1, 40, cycles, busy_cycles);
    check_output("sll31_done_cycle", 32'(cycles), 32'd32);
    check_output("sll31_busy_cycles", 32'(busy_cycles), 32'd31);
    check_output("sll31_result", bus.data_out, 32'h8000_0000);

    // SRA and SRL of 0x800000F0 by 4.
    apply_stimulus(2'b10, 32'h8000_00F0, 5'd4);
    wait_done(1, 10, cycles, busy_cycles);
    check_output("sra4_done_cycle", 32'(cycles), 32'd5);
    check_output("sra4_result", bus.data_out, 32'hF800_000F);
    apply_stimulus(2'b01, 32'h8000_00F0, 5'd4);
    wait_done(1, 10, cycles, busy_cycles);
    check_output("srl4_done_cycle", 32'(cycles), 32'd5);
    check_output("srl4_result", bus.data_out, 32'h0800_000F);

    // Zero amount, then ROTL by 1.
    apply_stimulus(2'b01, 32'hDEAD_BEEF, 5'd0);
    wait_done(1, 5, cycles, busy_cycles);
    check_output("zero_done_cycle", 32'(cycles), 32'd1);
    check_output("zero_busy_cycles", 32'(busy_cycles), 32'd0);
    check_output("zero_result", bus.data_out, 32'hDEAD_BEEF);
    apply_stimulus(2'b11, 32'h8000_0001, 5'd1);
    wait_done(1, 5, cycles, busy_cycles);
    check_output("rotl1_done_cycle", 32'(cycles), 32'd2);
    check_output("rotl1_result", bus.data_out, 32'h0000_0003);

    // Start pulsed with changing operands during SHIFT is ignored.
    @(negedge clk);
    done_before = done_count;
    apply_stimulus(2'b00, 32'h0000_0003, 5'd6);
    for (int i = 1; i <= 5; i++) begin
      bus.start   = (i % 2 == 1);
      bus.op      = 2'(i);
      bus.data_in = $urandom;
      bus.shamt   = 5'(i);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_done(6, 15, cycles, busy_cycles);
    check_output("ignore_done_cycle", 32'(cycles), 32'd7);
    check_output("ignore_result", bus.data_out, 32'h0000_00C0);
    @(negedge clk);
    check_output("ignore_done_pulses", 32'(done_count - done_before), 32'd1);
    check_output("ignore_back_to_idle", 32'({bus.busy, bus.done}), 32'h0);

    // Back-to-back: new start held in the DONE cycle.
    done_before = done_count;
    apply_stimulus(2'b01, 32'h0000_0100, 5'd2);
    wait_done(1, 10, cycles, busy_cycles);
    check_output("b2b_a_done_cycle", 32'(cycles), 32'd3);
    check_output("b2b_a_result", bus.data_out, 32'h0000_0040);
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h0000_0005;
    bus.shamt   = 5'd3;
    @(negedge clk);
    bus.start   = 1'b0;
    check_output("b2b_b_busy_rises", 32'(bus.busy), 32'h1);
    check_output("b2b_hold_during_shift", bus.data_out, 32'h0000_0040);
    wait_done(1, 10, cycles, busy_cycles);
    check_output("b2b_b_done_cycle", 32'(cycles), 32'd4);
    check_output("b2b_b_result", bus.data_out, 32'h0000_0028);
    @(negedge clk);
    check_output("b2b_done_pulses", 32'(done_count - done_before), 32'd2);
    check_output("b2b_done_single_cycle", 32'(bus.done), 32'h0);

    // Reset in the 3rd SHIFT cycle discards the operation.
    done_before = done_count;
    apply_stimulus(2'b00, 32'h0000_FFFF, 5'd10);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_busy", 32'(bus.busy), 32'h0);
    check_output("midreset_done", 32'(bus.done), 32'h0);
    check_output("midreset_data_out", bus.data_out, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_output("midreset_no_done", 32'(done_count - done_before), 32'd0);
    apply_stimulus(2'b01, 32'hFFFF_0000, 5'd8);
    wait_done(1, 15, cycles, busy_cycles);
    check_output("after_reset_done_cycle", 32'(cycles), 32'd9);
    check_output("after_reset_result", bus.data_out, 32'h00FF_FF00);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle variable-amount shift unit for the processor datapath. It sequences a single one-bit shift stage over successive cycles to execute SLL, SRL, SRA and ROTL by a 5-bit amount. A start/busy/done handshake lets the execute-stage control stall on it. The last result is held until the next operation completes.

## Interface
- WIDTH, 32, data width in bits.
- SHAMT_WIDTH, 5, shift-amount width; must satisfy 2^SHAMT_WIDTH >= WIDTH.
- clk  input  1  rising-edge clock; sole clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL; captured with start.
- data_in  input  WIDTH  operand; captured with start.
- shamt  input  SHAMT_WIDTH  shift amount, unsigned; captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; high only in DONE.
- data_out  output  WIDTH  result register.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free; busy and done are decoded from state, with no combinational path from inputs.
- Internal registers: acc (WIDTH), cnt (SHAMT_WIDTH), op_q (2), result (WIDTH) driving data_out.
- IDLE or DONE with start=1 at an edge:
  - load acc=data_in, cnt=shamt, op_q=op;
  - next state is DONE if shamt==0, otherwise SHIFT;
  - on the shamt==0 path, result also loads data_in at that same edge.
- IDLE or DONE with start=0: next state is IDLE.
- SHIFT, each edge:
  - acc is shifted by one position per op_q;
  - cnt decrements by 1;
  - if cnt==1, the shifted acc is written to result and the next state is DONE; otherwise the state stays SHIFT.
- Shift rules, per single step:
  - SLL: {acc[W-2:0],0}.
  - SRL: {0,acc[W-1:1]}.
  - SRA: {acc[W-1],acc[W-1:1]}.
  - ROTL: {acc[W-2:0],acc[W-1]}.
- start is ignored in SHIFT. A request must be re-presented after done.
- op/data_in/shamt are don't-care except at the accepting edge. Changing them mid-operation has no effect.
- data_out changes only at the edge entering DONE. It holds across IDLE and during later SHIFT cycles.
- Back-to-back: start asserted in the DONE cycle is accepted. done still pulses exactly one cycle for the finished op.
- shamt >= WIDTH (only possible if SHAMT_WIDTH is oversized) executes literally: SLL/SRL give 0, SRA gives sign fill, ROTL gives rotate mod WIDTH.

## Timing
- Reset (synchronous, takes priority over everything, including mid-SHIFT):
  - state=IDLE, busy=0, done=0, data_out=0;
  - acc/cnt/op_q=0;
  - any in-flight operation is discarded with no done pulse.
- Latency, with E0 as the edge sampling start:
  - shamt=0: DONE in the cycle after E0 (1 cycle).
  - shamt=n>0: busy high for n cycles after E0, then done high in the cycle after edge E0+n (n+1 cycles from start to done).
- data_out is valid in the done cycle and stable until the next DONE entry or reset.
- Throughput: one op per shamt+1 cycles (min 1) with back-to-back starts.
- busy and done are never high together.

## Test plan
- Reset: hold reset for 2 cycles with start=1 and random inputs -> busy=0, done=0, data_out=0x00000000; the first start after reset is accepted normally.
- SLL: data_in=0x00000001, shamt=31 -> busy for 31 cycles, done in cycle 32 after the accepting edge, data_out=0x80000000; data_out stays 0 during SHIFT.
- SRA/SRL: data_in=0x800000F0, shamt=4 -> SRA gives 0xF800000F, SRL gives 0x0800000F, done 5 cycles after start.
- Zero amount and ROTL:
  - op=SRL, data_in=0xDEADBEEF, shamt=0 -> done 1 cycle after start, data_out=0xDEADBEEF, busy never high;
  - then ROTL of 0x80000001 by 1 -> 0x00000003.
- Handshake:
  - start pulsed repeatedly during SHIFT, with changing data_in/op/shamt -> ignored, result unaffected;
  - start held high in the DONE cycle -> new op accepted, busy rises next cycle, and done pulses exactly once per op.
- Reset mid-op: SLL 0x0000FFFF by 10, reset asserted at the 3rd SHIFT cycle -> next cycle IDLE, data_out=0, no done pulse; a following SRL 0xFFFF0000 by 8 -> 0x00FFFF00.
